// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle bitwise logic unit.
// It applies one of eight bitwise operations to two latched operands, CHUNK bits per cycle.
// The completed word is published on out, with zero and parity flags, together with a
// one-cycle done pulse.
module logic_unit_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             parity
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] full_res;
  logic             last_chunk;

  assign last_chunk = (cnt == LAST_CNT);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  // State register; reset drops straight back to IDLE, which abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start is honoured only in IDLE, and DONE always lasts a single cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last_chunk) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Whole-word result of the latched operation; the chunk merge below keeps only the current slice
  always_comb begin
    full_res = '0;
    case (op_reg)
      3'b000: full_res = a_reg & b_reg;
      3'b001: full_res = a_reg | b_reg;
      3'b010: full_res = a_reg ^ b_reg;
      3'b011: full_res = ~(a_reg ^ b_reg);
      3'b100: full_res = ~(a_reg & b_reg);
      3'b101: full_res = ~(a_reg | b_reg);
      3'b110: full_res = ~a_reg;
      3'b111: full_res = a_reg;
      default: full_res = '0;
    endcase
  end

  // Insert the chunk selected by the counter into the accumulator
  always_comb begin
    acc_next = acc;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        acc_next[k*CHUNK +: CHUNK] = full_res[k*CHUNK +: CHUNK];
      end
    end
  end

  // Datapath: operands are captured at acceptance so later input changes cannot disturb the run.
  // out, zero and parity change only when the final chunk lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_reg <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      out    <= '0;
      zero   <= 1'b1;
      parity <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            cnt    <= '0;
            acc    <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (last_chunk) begin
            out    <= acc_next;
            zero   <= ~|acc_next;
            parity <= ^acc_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: scoreboard bench for logic_unit_seq (32/8 instance plus a 16/16 instance).
module tb_logic_unit_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'b000;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        zero;
  logic        parity;

  logic        start2 = 1'b0;
  logic [2:0]  op2    = 3'b000;
  logic [15:0] a2     = '0;
  logic [15:0] b2     = '0;
  logic        busy2;
  logic        done2;
  logic [15:0] out2;
  logic        zero2;
  logic        parity2;

  typedef struct {
    logic [31:0] res;
    int          acc_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          errors   = 0;
  int          checks   = 0;
  int          cool     = 0;
  int          cyc      = 0;
  logic [31:0] last_out = '0;

  logic_unit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .zero(zero), .parity(parity)
  );

  logic_unit_seq #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .out(out2), .zero(zero2), .parity(parity2)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return x ^ y;
      3'b011: return ~(x ^ y);
      3'b100: return ~(x & y);
      3'b101: return ~(x | y);
      3'b110: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Acceptance model: decides which start edges are taken and pushes the expected result
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cool     = 0;
      last_out = '0;
      exp_q.delete();
    end else begin
      cyc++;
      if (cool > 0) begin
        cool--;
      end else if (start) begin
        exp_q.push_back('{model_op(op, a, b), cyc});
        cool = NCHUNK + 1;
      end
    end
  end

  // Output monitor: compares handshake and result outputs just after every rising edge
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious done", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        checkOutput("latency", 32'(cyc - cur.acc_cyc), 32'(NCHUNK));
        last_out = cur.res;
      end
    end
    checkOutput("busy", 32'(busy), 32'(cool >= 2));
    checkOutput("done", 32'(done), 32'(cool == 1));
    checkOutput("out", out, last_out);
    checkOutput("zero", 32'(zero), 32'(last_out == '0));
    checkOutput("parity", 32'(parity), 32'(^last_out));
  end

  // One operation: start for a single cycle, operands scrambled right after acceptance
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic [2:0] o);
    start = 1'b1;
    a     = x;
    b     = y;
    op    = o;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 3'($urandom_range(0, 7));
    repeat (NCHUNK + 1) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset out", out, 32'h0);
    checkOutput("reset zero", 32'(zero), 32'd1);
    checkOutput("reset parity", 32'(parity), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'h00000000, 32'h00000000, 3'b011);
    checkOutput("xnor zeros", out, 32'hFFFFFFFF);
    applyStimulus(32'hFFDF1F40, 32'h80031F4F, 3'b011);
    checkOutput("xnor vec", out, 32'h8023FFF0);
    applyStimulus(32'hFFDF1F40, 32'h80031F4F, 3'b010);
    checkOutput("xor vec", out, 32'h7FDC000F);
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 3'b000);
    checkOutput("and zero", out, 32'h00000000);
    checkOutput("and zero flag", 32'(zero), 32'd1);
    applyStimulus(32'h00000001, 32'h00000000, 3'b110);
    checkOutput("not a", out, 32'hFFFFFFFE);
    checkOutput("not a parity", 32'(parity), 32'd1);

    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom, $urandom, 3'(i));
    end

    for (int i = 0; i < 40; i++) begin
      start = 1'b1;
      a     = $urandom;
      b     = $urandom;
      op    = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (NCHUNK + 2) @(negedge clk);

    applyStimulus(32'h12345678, 32'h0F0F0F0F, 3'b010);
    checkOutput("pre-reset out", out, 32'h1D3B5977);
    start = 1'b1;
    a     = 32'hA5A5A5A5;
    b     = 32'h5A5A5A5A;
    op    = 3'b001;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async rst busy", 32'(busy), 32'd0);
    checkOutput("async rst done", 32'(done), 32'd0);
    checkOutput("async rst out", out, 32'h0);
    checkOutput("async rst zero", 32'(zero), 32'd1);
    checkOutput("async rst parity", 32'(parity), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NCHUNK + 3) @(negedge clk);
    applyStimulus(32'h0000FFFF, 32'h00FF00FF, 3'b100);
    checkOutput("post-reset nand", out, 32'hFFFFFF00);

    start2 = 1'b1;
    a2     = 16'h00FF;
    b2     = 16'h0F0F;
    op2    = 3'b001;
    @(posedge clk);
    #1;
    checkOutput("w16 busy T0", 32'(busy2), 32'd1);
    checkOutput("w16 done T0", 32'(done2), 32'd0);
    @(negedge clk);
    start2 = 1'b0;
    a2     = 16'h0000;
    b2     = 16'h0000;
    @(posedge clk);
    #1;
    checkOutput("w16 done T1", 32'(done2), 32'd1);
    checkOutput("w16 busy T1", 32'(busy2), 32'd0);
    checkOutput("w16 out", 32'(out2), 32'h0FFF);
    checkOutput("w16 parity", 32'(parity2), 32'd0);
    checkOutput("w16 zero", 32'(zero2), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("w16 done T2", 32'(done2), 32'd0);
    checkOutput("w16 out hold", 32'(out2), 32'h0FFF);
    @(negedge clk);

    repeat (NCHUNK + 2) @(negedge clk);
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_unit_seq.md
LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have port op, input, 3, operation select.
REQ-007 The block SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 The block SHALL have port busy, output, 1, operation in progress.
REQ-009 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-010 The block SHALL have port out, output, WIDTH, result of last completed operation.
REQ-011 The block SHALL have port zero, output, 1, high when last completed result is all zeros.
REQ-012 The block SHALL have port parity, output, 1, XOR-reduction of last completed result.

Function
REQ-013 op encoding SHALL be 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT a, 111 pass a; all bitwise.
REQ-014 The FSM SHALL have states IDLE, RUN, DONE.
REQ-015 In IDLE, start=1 at edge T0 SHALL latch a, b, op into internal registers, clear chunk counter to 0, enter RUN; busy=1 from T0.
REQ-016 In RUN, each edge T1..TNCHUNK SHALL compute bits [k*CHUNK +: CHUNK] of the latched operands into an internal accumulator, k = counter, then increment counter.
REQ-017 At edge TNCHUNK the FSM SHALL enter DONE, load out from the completed accumulator, update zero and parity, set done=1, busy=0.
REQ-018 At the edge after DONE the FSM SHALL return to IDLE with done=0; done SHALL be high exactly one cycle per operation.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing; minimum start-to-start spacing is NCHUNK+2 cycles.
REQ-020 Changes on a, b, op after T0 SHALL NOT affect the operation in progress.
REQ-021 out, zero, parity SHALL hold their values between done pulses, including while busy.
REQ-022 The chunk counter SHALL be $clog2(NCHUNK) bits (minimum 1) and SHALL NOT wrap within an operation; it is reset to 0 on each accepted start.
REQ-023 With CHUNK=WIDTH (NCHUNK=1) the block SHALL take one RUN cycle: busy high one cycle, done at T1.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force state IDLE, counter 0, accumulator 0, busy=0, done=0, out=0, zero=1, parity=0.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-027 Defaults, a=00000000, b=00000000, op=011, start pulse at T0 -> busy high T0..T3, done high only after T4, out=FFFFFFFF, zero=0, parity=0.
REQ-028 a=FFDF1F40, b=80031F4F, op=011 -> out=8023FFF0, zero=0, parity=0; op=010 same operands -> out=7FDC000F, parity=0.
REQ-029 a=FFFFFFFF, b=00000000, op=000 -> out=00000000, zero=1; then op=110, a=00000001 -> out=FFFFFFFE, parity=1.
REQ-030 start held high continuously with changing a/b -> one operation per NCHUNK+2 cycles, each result matching operands sampled at its own accepted start edge.
REQ-031 rst_n pulsed low at T2 of an operation -> outputs at reset values asynchronously, no done pulse afterward, next start completes normally.
REQ-032 Instance WIDTH=16, CHUNK=16, a=00FF, b=0F0F, op=001 -> done at T1, out=0FFF, parity=0.
